// File: rtl/alu_op_pipe_if.sv
// Command/ALU/result signal bundle for alu_op_pipe.
// The slave modport is the pipe itself; the master modport is whoever drives commands and hosts the ALU.
interface alu_op_pipe_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_sel;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_result;
    logic       alu_zero;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_zero;
    logic [2:0] out_sel;

    modport slave (
        input  in_valid, in_a, in_b, in_sel,
        input  alu_result, alu_zero,
        input  out_ready,
        output in_ready,
        output alu_a, alu_b, alu_sel,
        output out_valid, out_result, out_zero, out_sel
    );

    modport master (
        output in_valid, in_a, in_b, in_sel,
        output alu_result, alu_zero,
        output out_ready,
        input  in_ready,
        input  alu_a, alu_b, alu_sel,
        input  out_valid, out_result, out_zero, out_sel
    );
endinterface

// File: rtl/alu_op_pipe.sv
// Two-stage elastic pipe wrapped around an external combinational ALU: S1 holds the operands
// presented to the ALU, S2 captures its result; op_count counts consumed results.
module alu_op_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_pipe_if.slave     bus,
    output logic [CNT_W-1:0] op_count
);

    // S1: operand stage feeding the ALU
    logic       s1_valid_reg, s1_valid_next;
    logic [7:0] alu_a_reg, alu_a_next;
    logic [7:0] alu_b_reg, alu_b_next;
    logic [2:0] alu_sel_reg, alu_sel_next;

    // S2: result stage
    logic       out_valid_reg, out_valid_next;
    logic [7:0] out_result_reg, out_result_next;
    logic       out_zero_reg, out_zero_next;
    logic [2:0] out_sel_reg, out_sel_next;

    logic [CNT_W-1:0] op_count_reg, op_count_next;

    logic s1_adv;
    logic in_ready;
    logic in_fire;
    logic out_fire;

    // S1 may move forward whenever S2 is empty or being drained this cycle.
    assign s1_adv   = s1_valid_reg & (~out_valid_reg | bus.out_ready);
    assign in_ready = ~s1_valid_reg | s1_adv;
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = out_valid_reg & bus.out_ready;

    always_comb begin
        s1_valid_next = s1_valid_reg;
        alu_a_next    = alu_a_reg;
        alu_b_next    = alu_b_reg;
        alu_sel_next  = alu_sel_reg;
        if (in_fire) begin
            s1_valid_next = 1'b1;
            alu_a_next    = bus.in_a;
            alu_b_next    = bus.in_b;
            alu_sel_next  = bus.in_sel;
        end else if (s1_adv) begin
            s1_valid_next = 1'b0;
        end
    end

    // A refill from S1 wins over a drain so out_valid stays high on back-to-back results.
    always_comb begin
        out_valid_next  = out_valid_reg;
        out_result_next = out_result_reg;
        out_zero_next   = out_zero_reg;
        out_sel_next    = out_sel_reg;
        if (s1_adv) begin
            out_valid_next  = 1'b1;
            out_result_next = bus.alu_result;
            out_zero_next   = bus.alu_zero;
            out_sel_next    = alu_sel_reg;
        end else if (out_fire) begin
            out_valid_next = 1'b0;
        end
    end

    always_comb begin
        op_count_next = op_count_reg;
        if (out_fire) begin
            op_count_next = op_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            alu_a_reg    <= 8'h00;
            alu_b_reg    <= 8'h00;
            alu_sel_reg  <= 3'b000;
        end else begin
            s1_valid_reg <= s1_valid_next;
            alu_a_reg    <= alu_a_next;
            alu_b_reg    <= alu_b_next;
            alu_sel_reg  <= alu_sel_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= 8'h00;
            out_zero_reg   <= 1'b0;
            out_sel_reg    <= 3'b000;
            op_count_reg   <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_result_reg <= out_result_next;
            out_zero_reg   <= out_zero_next;
            out_sel_reg    <= out_sel_next;
            op_count_reg   <= op_count_next;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.alu_a      = alu_a_reg;
    assign bus.alu_b      = alu_b_reg;
    assign bus.alu_sel    = alu_sel_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_result = out_result_reg;
    assign bus.out_zero   = out_zero_reg;
    assign bus.out_sel    = out_sel_reg;
    assign op_count       = op_count_reg;

endmodule

// File: tb/tb_alu_op_pipe.sv
// Bench for alu_op_pipe: behavioural ALU behind the pipe, scoreboard of expected results
// filled on command acceptance and drained on result consumption, plus directed scenario tasks.
module tb_alu_op_pipe;

    logic clk;
    logic rst_n;

    alu_op_pipe_if bus();
    alu_op_pipe_if bus4();

    logic [15:0] op_count;
    logic [3:0]  op_count4;

    int total;
    int bad;
    int pops;

    logic [11:0] sb[$];

    alu_op_pipe #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .op_count (op_count)
    );

    alu_op_pipe #(.CNT_W(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus4),
        .op_count (op_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: {zero, result}
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        logic [7:0] r;
        case (s)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = a << 1;
            3'd6:    r = a >> 1;
            default: r = a;
        endcase
        return {(r == 8'h00), r};
    endfunction

    logic [8:0] alu_out;
    logic [8:0] alu4_out;
    assign alu_out         = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);
    assign bus.alu_result  = alu_out[7:0];
    assign bus.alu_zero    = alu_out[8];
    assign alu4_out        = alu_f(bus4.alu_a, bus4.alu_b, bus4.alu_sel);
    assign bus4.alu_result = alu4_out[7:0];
    assign bus4.alu_zero   = alu4_out[8];

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_a      = bus.in_a;
    assign bus4.in_b      = bus.in_b;
    assign bus4.in_sel    = bus.in_sel;
    assign bus4.out_ready = bus.out_ready;

    // Scoreboard monitor: sampled mid-cycle, inputs only change just after rising edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                logic [8:0] e;
                e = alu_f(bus.in_a, bus.in_b, bus.in_sel);
                sb.push_back({bus.in_sel, e});
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                pops++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got result=%h sel=%0d, required no output", bus.out_result, bus.out_sel);
                end else begin
                    logic [11:0] exp_v;
                    exp_v = sb.pop_front();
                    if ({bus.out_sel, bus.out_zero, bus.out_result} !== exp_v) begin
                        bad++;
                        $display("FAIL sb_result: got sel=%0d zero=%0b result=%h, required sel=%0d zero=%0b result=%h",
                                 bus.out_sel, bus.out_zero, bus.out_result, exp_v[11:9], exp_v[8], exp_v[7:0]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        step();
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        total++;
        if ({bus.out_valid, bus.out_zero, bus.out_result, bus.out_sel} !== 13'h0) begin
            bad++; $display("FAIL reset_s2: got valid=%b zero=%b result=%h sel=%0d required all 0",
                            bus.out_valid, bus.out_zero, bus.out_result, bus.out_sel);
        end
        total++;
        if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== 19'h0) begin
            bad++; $display("FAIL reset_s1: got a=%h b=%h sel=%0d required 0", bus.alu_a, bus.alu_b, bus.alu_sel);
        end
        total++;
        if (op_count !== 16'h0) begin bad++; $display("FAIL reset_count: got %0d required 0", op_count); end
        step();
        #2 rst_n = 1'b1;
        step();
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready: got %b required 1", bus.in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_add();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = 8'h0F; bus.in_b = 8'h01; bus.in_sel = 3'd0;
        step();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.alu_a !== 8'h0F) begin
            bad++; $display("FAIL add_s1: got out_valid=%b alu_a=%h required 0 / 0f", bus.out_valid, bus.alu_a);
        end
        step();
        total++;
        if ({bus.out_valid, bus.out_result, bus.out_zero, bus.out_sel} !== {1'b1, 8'h10, 1'b0, 3'd0}) begin
            bad++; $display("FAIL add_out: got valid=%b result=%h zero=%b sel=%0d required 1/10/0/0",
                            bus.out_valid, bus.out_result, bus.out_zero, bus.out_sel);
        end
        step();
        total++;
        if (op_count !== 16'd1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL add_count: got count=%0d valid=%b required 1 / 0", op_count, bus.out_valid);
        end
        $display("test_add done");
    endtask

    task automatic test_sub_zero();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = 8'h05; bus.in_b = 8'h05; bus.in_sel = 3'd1;
        step();
        bus.in_valid = 1'b0;
        step();
        total++;
        if ({bus.out_valid, bus.out_result, bus.out_zero, bus.out_sel} !== {1'b1, 8'h00, 1'b1, 3'd1}) begin
            bad++; $display("FAIL sub_zero: got valid=%b result=%h zero=%b sel=%0d required 1/00/1/1",
                            bus.out_valid, bus.out_result, bus.out_zero, bus.out_sel);
        end
        step();
        $display("test_sub_zero done");
    endtask

    task automatic test_backpressure();
        logic [15:0] base;
        base = op_count;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 8'h01; bus.in_b = 8'h01; bus.in_sel = 3'd0;
        step();
        bus.in_a = 8'h02; bus.in_b = 8'h02;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_second_ready: got %b required 1", bus.in_ready); end
        step();
        bus.in_a = 8'h03; bus.in_b = 8'h03;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.in_ready !== 1'b0 || bus.out_result !== 8'h02 || bus.out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_full: got in_ready=%b valid=%b result=%h required 0/1/02",
                                bus.in_ready, bus.out_valid, bus.out_result);
            end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b required 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 8'h04) begin
            bad++; $display("FAIL bp_second: got valid=%b result=%h required 1/04", bus.out_valid, bus.out_result);
        end
        step();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 8'h06) begin
            bad++; $display("FAIL bp_third: got valid=%b result=%h required 1/06", bus.out_valid, bus.out_result);
        end
        step();
        total++;
        if (bus.out_valid !== 1'b0 || op_count !== base + 16'd3) begin
            bad++; $display("FAIL bp_drain: got valid=%b count=%0d required 0/%0d", bus.out_valid, op_count, base + 16'd3);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_streaming();
        logic [15:0] base;
        base = op_count;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                bus.in_valid = 1'b1;
                bus.in_a = 8'(i * 16 + 3); bus.in_b = 8'(i); bus.in_sel = 3'(i + 2);
                total++;
                if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d]: got %b required 1", i, bus.in_ready); end
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
            total++;
            if (bus.out_valid !== (i >= 1 && i <= 4)) begin
                bad++; $display("FAIL stream_valid[%0d]: got %b required %b", i, bus.out_valid, (i >= 1 && i <= 4));
            end
        end
        total++;
        if (op_count !== base + 16'd4) begin bad++; $display("FAIL stream_count: got %0d required %0d", op_count, base + 16'd4); end
        $display("test_streaming done");
    endtask

    task automatic test_random();
        logic [15:0] base;
        int p0;
        int n;
        base = op_count;
        p0 = pops;
        for (int i = 0; i < 200; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_a      = 8'($urandom);
            bus.in_b      = 8'($urandom);
            bus.in_sel    = 3'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 10) begin
            step();
            n++;
        end
        total++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL rand_drain: got %0d pending, valid=%b required 0/0", sb.size(), bus.out_valid);
        end
        total++;
        if (op_count !== base + 16'(pops - p0)) begin
            bad++; $display("FAIL rand_count: got %0d required %0d", op_count, base + 16'(pops - p0));
        end
        $display("test_random done: %0d results", pops - p0);
    endtask

    task automatic test_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1; bus.in_a = 8'(i); bus.in_b = 8'(3 * i); bus.in_sel = 3'd0;
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        total++;
        if (op_count !== 16'd17) begin bad++; $display("FAIL wrap_count16: got %0d required 17", op_count); end
        total++;
        if (op_count4 !== 4'd1) begin bad++; $display("FAIL wrap_count4: got %0d required 1", op_count4); end
        $display("test_wrap done");
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 8'h11; bus.in_b = 8'h22; bus.in_sel = 3'd4;
        step();
        bus.in_a = 8'h33;
        step();
        bus.in_valid = 1'b0;
        total++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL mid_full: got valid=%b in_ready=%b required 1/0", bus.out_valid, bus.in_ready);
        end
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || op_count !== 16'd0 || bus.in_ready !== 1'b1 || bus.alu_a !== 8'h00) begin
            bad++; $display("FAIL mid_async: got valid=%b count=%0d in_ready=%b alu_a=%h required 0/0/1/00",
                            bus.out_valid, op_count, bus.in_ready, bus.alu_a);
        end
        step();
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d]: got valid=%b required 0", i, bus.out_valid); end
        end
        bus.in_valid = 1'b1; bus.in_a = 8'h07; bus.in_b = 8'h09; bus.in_sel = 3'd0;
        step();
        bus.in_valid = 1'b0;
        step();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 8'h10) begin
            bad++; $display("FAIL mid_first: got valid=%b result=%h required 1/10", bus.out_valid, bus.out_result);
        end
        step();
        total++;
        if (op_count !== 16'd1) begin bad++; $display("FAIL mid_count: got %0d required 1", op_count); end
        $display("test_reset_midflight done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad = 0;
        pops = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = 8'h00;
        bus.in_b = 8'h00;
        bus.in_sel = 3'd0;
        bus.out_ready = 1'b0;
        #3;
        test_reset();
        test_add();
        test_sub_zero();
        test_backpressure();
        test_streaming();
        test_random();
        test_wrap();
        test_reset_midflight();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending required 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_pipe.md
ALU_OP_PIPE -- requirements
Module: alu_op_pipe

Interface
REQ-001 Parameter: CNT_W, 16, width of completed-operation counter op_count.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream command valid.
REQ-005 in_ready  output  1  block accepts command this cycle.
REQ-006 in_a, in_b  input  8 each  operands.
REQ-007 in_sel  input  3  ALU opcode (000 ADD … 111 NOP).
REQ-008 alu_a, alu_b  output  8 each  registered operands driven to the downstream combinational ALU.
REQ-009 alu_sel  output  3  registered opcode driven to the ALU.
REQ-010 alu_result  input  8  ALU result for alu_a/alu_b/alu_sel.
REQ-011 alu_zero  input  1  ALU zero flag.
REQ-012 out_valid  output  1  result register holds valid data.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_result  output  8  captured ALU result.
REQ-015 out_zero  output  1  captured zero flag.
REQ-016 out_sel  output  3  opcode that produced out_result.
REQ-017 op_count  output  CNT_W  number of results consumed.

Function
REQ-018 Two register stages SHALL exist: S1 (s1_valid, alu_a, alu_b, alu_sel) and S2 (out_valid, out_result, out_zero, out_sel).
REQ-019 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-020 s1_adv SHALL equal s1_valid & (~out_valid | out_ready).
REQ-021 in_ready SHALL equal ~s1_valid | s1_adv (combinational path from out_ready is permitted).
REQ-022 On in_fire, S1 SHALL load in_a, in_b, in_sel and set s1_valid.
REQ-023 On s1_adv without in_fire, s1_valid SHALL clear; alu_a/alu_b/alu_sel SHALL hold their last values.
REQ-024 On s1_adv, S2 SHALL load alu_result, alu_zero, alu_sel and set out_valid.
REQ-025 On out_fire without s1_adv, out_valid SHALL clear; out_result/out_zero/out_sel SHALL hold.
REQ-026 Simultaneous out_fire and s1_adv: out_valid SHALL remain 1 with new data; simultaneous in_fire and s1_adv: S1 SHALL take the new command.
REQ-027 When a stage is not advancing, its registers SHALL hold unchanged; no command is dropped or duplicated.
REQ-028 Latency: command accepted on edge N SHALL appear with out_valid=1 after edge N+1; throughput SHALL be one command per cycle when out_ready=1.
REQ-029 Results SHALL leave in acceptance order; capacity SHALL be exactly 2 commands.
REQ-030 op_count SHALL increment by 1 on each out_fire, wrapping modulo 2^CNT_W.
REQ-031 The block SHALL NOT interpret opcodes; NOP and unused codes pass through like any other.

Reset
REQ-032 rst_n low SHALL immediately clear s1_valid, out_valid, alu_a, alu_b, alu_sel, out_result, out_sel, op_count to 0 and set out_zero to 0.
REQ-033 Reset mid-operation SHALL discard all in-flight commands; the first command after rst_n rises SHALL behave as the first ever issued.
REQ-034 in_ready SHALL be 1 during and immediately after reset (both stages empty).

Verification
REQ-035 ADD: a=8'h0F, b=8'h01, sel=000, out_ready=1 -> out_valid after second edge, out_result=8'h10, out_zero=0, out_sel=000, op_count=1.
REQ-036 SUB zero: a=8'h05, b=8'h05, sel=001 -> out_result=8'h00, out_zero=1.
REQ-037 Backpressure: out_ready=0, offer ADD 1+1, 2+2, 3+3 back-to-back -> first two accepted, in_ready=0 for third; raise out_ready -> results 8'h02, 8'h04, 8'h06 in order, none lost.
REQ-038 Streaming: four commands on consecutive cycles, out_ready=1 -> four results on four consecutive cycles, op_count=4.
REQ-039 Wrap: CNT_W=4, 17 results consumed -> op_count=1.
REQ-040 Reset mid-flight: both stages full, pulse rst_n low asynchronously between edges -> out_valid and op_count drop to 0 immediately, in_ready=1, no stale result emitted afterward.
